// File: rtl/rom_boot_loader.sv
// rom_boot_loader: downloads a length-prefixed, little-endian byte stream
// into consecutive instruction ROM words while holding the CPU stalled.
module rom_boot_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        rom_we,
    output logic [31:0] rom_addr,
    output logic [31:0] rom_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  words_loaded
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    logic [7:0]    len_lo;
    logic [15:0]   len;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic [TW-1:0] tcnt;

    logic          xfer;
    logic          expired;
    logic          len_bad;
    logic          last_word;
    logic [15:0]   len_in;

    // Status flags decode straight from the state register.
    assign rx_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA);
    assign busy      = rx_ready || (state == S_WRITE);
    assign cpu_hold  = busy || error;

    assign xfer      = rx_valid && rx_ready;
    assign expired   = !xfer && (tcnt == TLAST);
    assign len_in    = {rx_data, len_lo};
    assign len_bad   = (len_in == 16'd0) || (32'(len_in) > DEPTH);
    assign last_word = (16'(words_loaded) + 16'd1) == len;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state        <= S_IDLE;
            rom_we       <= 1'b0;
            rom_addr     <= 32'd0;
            rom_data     <= 32'd0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 9'd0;
            len_lo       <= 8'd0;
            len          <= 16'd0;
            byte_idx     <= 2'd0;
            word_buf     <= 24'd0;
            tcnt         <= '0;
        end else begin
            rom_we <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_LEN_LO;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= 9'd0;
                        byte_idx     <= 2'd0;
                        tcnt         <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo <= rx_data;
                        tcnt   <= '0;
                        state  <= S_LEN_HI;
                    end else if (expired) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len      <= len_in;
                        tcnt     <= '0;
                        byte_idx <= 2'd0;
                        if (len_bad) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end else if (expired) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        tcnt     <= '0;
                        byte_idx <= byte_idx + 2'd1;
                        unique case (byte_idx)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                // The 4th byte goes straight to the write port.
                                rom_we   <= 1'b1;
                                rom_addr <= BASE_ADDR + 32'(words_loaded);
                                rom_data <= {rx_data, word_buf};
                                state    <= S_WRITE;
                            end
                        endcase
                    end else if (expired) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_loaded + 9'd1;
                    byte_idx     <= 2'd0;
                    if (last_word) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_DATA;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_boot_loader.sv
// tb_rom_boot_loader: scoreboard bench; expected ROM writes come from a
// byte-stream model and are popped by a monitor on every rom_we pulse.
module tb_rom_boot_loader;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'd0;
    localparam int unsigned TMO   = 16;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        rom_we;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  stream[$];
    int          exp_words;
    bit          exp_done;
    bit          exp_err;
    int          exp_tmo;

    rom_boot_loader #(
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE),
        .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK),
        .RST_n(RST_n),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rom_we(rom_we),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge CLK) begin
        logic [63:0] e;
        if (rom_we) begin
            chk("ready_low_in_write", {31'd0, rx_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: addr 0x%0h data 0x%0h, no write expected",
                         rom_addr, rom_data);
            end else begin
                e = exp_q.pop_front();
                chk("rom_addr", rom_addr, e[63:32]);
                chk("rom_data", rom_data, e[31:0]);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_rom_we"}, {31'd0, rom_we}, 32'd0);
        chk({tag, "_rom_addr"}, rom_addr, 32'd0);
        chk({tag, "_rom_data"}, rom_data, 32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_words"}, {23'd0, words_loaded}, 32'd0);
    endtask

    task automatic build(input int n, input int nd);
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        for (int i = 0; i < nd; i++) stream.push_back(8'($urandom));
    endtask

    // Reference: header gives N; every complete 4-byte group is a word.
    task automatic model_expect();
        int n;
        int nd;
        int w;
        bit legal;
        n = int'(stream[0]) | (int'(stream[1]) << 8);
        nd = stream.size() - 2;
        legal = (n != 0) && (n <= int'(DEPTH));
        w = legal ? nd / 4 : 0;
        for (int k = 0; k < w; k++)
            exp_q.push_back({BASE + 32'(k), stream[2+4*k+3], stream[2+4*k+2],
                             stream[2+4*k+1], stream[2+4*k]});
        exp_words = w;
        exp_done = legal && (nd == 4 * n);
        exp_err = !exp_done;
        exp_tmo = (legal && !exp_done) ?
                  int'(TMO) + ((nd > 0 && nd % 4 == 0) ? 1 : 0) : 0;
    endtask

    task automatic pulse_start();
        rx_valid = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        rx_data = b;
        rx_valid = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            got = rx_ready;
            @(negedge CLK);
        end
        chk("byte_accepted", {31'd0, got}, 32'd1);
    endtask

    task automatic send_stream(input bit gaps, input bit poke);
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i]);
            if (poke && i == 4) begin
                rx_valid = 1'b0;
                start = 1'b1;
                @(negedge CLK);
                start = 1'b0;
                chk("busy_after_poke", {31'd0, busy}, 32'd1);
                chk("words_after_poke", {23'd0, words_loaded}, 32'd0);
            end
            if (gaps && i + 1 < stream.size()) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge CLK);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic finish_load(input string tag);
        int k;
        k = 0;
        if (exp_tmo > 0) begin
            while (!error && k < 100) begin
                @(negedge CLK);
                k++;
            end
            chk({tag, "_timeout_edges"}, k, exp_tmo);
        end else begin
            while (busy && k < 100) begin
                @(negedge CLK);
                k++;
            end
            chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        end
        @(negedge CLK);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, exp_err});
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_words"}, {23'd0, words_loaded}, exp_words);
        chk({tag, "_pending"}, exp_q.size(), 32'd0);
    endtask

    task automatic run_load(input string tag, input bit gaps, input bit poke);
        pulse_start();
        chk({tag, "_start_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_start_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_start_words"}, {23'd0, words_loaded}, 32'd0);
        chk({tag, "_start_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_start_ready"}, {31'd0, rx_ready}, 32'd1);
        model_expect();
        send_stream(gaps, poke);
        finish_load(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int kind;
        int n;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST_n = 1'b1;
        @(negedge CLK);

        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h6F, 8'h00, 8'h00, 8'h00};
        run_load("normal", 1'b0, 1'b0);

        build(0, 0);
        run_load("len_zero", 1'b0, 1'b0);
        stream = '{8'h01, 8'h01};
        run_load("len_257", 1'b0, 1'b0);

        build(3, 5);
        run_load("timeout", 1'b0, 1'b0);
        build(3, 12);
        run_load("after_timeout", 1'b1, 1'b0);

        build(4, 6);
        pulse_start();
        model_expect();
        send_stream(1'b0, 1'b0);
        RST_n = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
        check_all_zero("midreset");
        chk("midreset_pending", exp_q.size(), 32'd0);
        rx_data = 8'hA5;
        rx_valid = 1'b1;
        repeat (6) @(negedge CLK);
        chk("midreset_ready", {31'd0, rx_ready}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        rx_valid = 1'b0;

        build(4, 16);
        run_load("poke", 1'b1, 1'b1);
        build(2, 8);
        run_load("restart_done", 1'b0, 1'b0);

        build(256, 1024);
        run_load("full_depth", 1'b0, 1'b0);

        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                n = $urandom_range(1, 6);
                build(n, 4 * n);
                run_load("rand_full", 1'($urandom_range(0, 1)),
                         1'(n >= 2 && $urandom_range(0, 1) == 1));
            end else if (kind == 1) begin
                n = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(257, 65535);
                build(n, 0);
                run_load("rand_badlen", 1'b0, 1'b0);
            end else begin
                n = $urandom_range(1, 4);
                build(n, $urandom_range(0, 4 * n - 1));
                run_load("rand_trunc", 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_boot_loader.md
Name: rom_boot_loader

Overview:
- Sequences run-time download of machine code into the instruction ROM through its write port (write enable, word address, 32-bit data).
- Consumes a byte stream (UART receiver or debug link) over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word to consecutive ROM word addresses and holds the CPU stalled until the image is complete.
- Sits between the byte-source front end and the ROM write port; the CPU fetch path is untouched.

Parameters:
- DEPTH, 256, ROM depth in words; largest legal image length.
- BASE_ADDR, 0, first ROM word address written.
- TIMEOUT, 100000, maximum idle cycles between accepted bytes during a load before aborting.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_n  in  1  synchronous active-low reset, sampled on rising CLK.
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- rom_we  out  1  ROM write enable, one-cycle pulse per word.
- rom_addr  out  32  ROM word address (word index, not byte address).
- rom_data  out  32  assembled word.
- cpu_hold  out  1  keeps the CPU stalled or reset while high.
- busy  out  1  load in progress.
- done  out  1  sticky; last load completed.
- error  out  1  sticky; last load aborted.
- words_loaded  out  9  words written in the current or last load.

Behaviour:
- Reset (RST_n low at a rising edge): state IDLE. All outputs 0: rx_ready, rom_we, rom_addr, rom_data, cpu_hold, busy, done, error, words_loaded. Byte and timeout counters cleared.
- Reset mid-load: aborts immediately to IDLE. Words already written stay in ROM; nothing else is written.
- Handshake: a byte transfers on a rising edge with rx_valid && rx_ready.
  - rx_ready is 1 only in LEN_LO, LEN_HI and DATA.
  - rx_ready is 0 in IDLE, WRITE, DONE and ERROR.
  - rx_valid with rx_ready low is ignored; no data loss is implied, because the source must hold the byte.
- States:
  - IDLE: start -> LEN_LO; clear done, error and words_loaded.
  - LEN_LO: accept byte as N[7:0] -> LEN_HI.
  - LEN_HI: accept byte as N[15:8].
    - If N==0 or N>DEPTH -> ERROR, with no ROM writes.
    - Otherwise -> DATA with word index 0 and byte index 0.
  - DATA: accept bytes into the word buffer, little-endian (byte 0 -> [7:0] ... byte 3 -> [31:24]). The 4th accepted byte -> WRITE.
  - WRITE: exactly one cycle.
    - Outputs: rom_we=1, rom_addr=BASE_ADDR+index, rom_data=buffer.
    - Next edge: index increments and words_loaded increments.
    - If the new count == N -> DONE; else -> DATA with byte index 0.
  - DONE: done=1 and cpu_hold=0. start -> LEN_LO, clearing done and words_loaded.
  - ERROR: error=1 and cpu_hold=1. start -> LEN_LO, clearing error and words_loaded.
- Latency: rom_we is high in the cycle immediately after the edge that accepted the word's 4th byte. Minimum load time is 2 + 5N cycles after start.
- rom_addr and rom_data hold their last written values outside WRITE. rom_we is 0 outside WRITE.
- busy = 1 in LEN_LO, LEN_HI, DATA and WRITE.
- cpu_hold = busy | error.
- start while busy is ignored.
- Timeout:
  - The counter clears on every accepted byte and on entry to LEN_LO.
  - It increments each cycle in LEN_LO, LEN_HI and DATA without a transfer.
  - Reaching TIMEOUT-1 with no transfer in that cycle -> ERROR. Words already written remain.
- Byte and transfer in the same cycle the timeout would expire: the transfer wins and the counter clears.
- words_loaded is 9 bits wide, enough to reach DEPTH=256.
- Address arithmetic is 32-bit unsigned; BASE_ADDR+N-1 must be <= DEPTH-1.

Test Plan:
- Reset and normal load: reset, then start; send 02 00 | 13 00 00 00 | 6F 00 00 00 with rx_valid always high.
  - rom_we pulses twice: addr 0 data 0x00000013, then addr 1 data 0x0000006F.
  - Then done=1, cpu_hold=0, words_loaded=2.
- Backpressure: hold rx_valid high continuously. rx_ready is 0 during each WRITE cycle, and no byte is consumed or duplicated; the written words match the input stream exactly.
- Bad length:
  - Header 00 00 -> error=1, cpu_hold=1, no rom_we.
  - Header 01 01 (N=257 > DEPTH) -> same response.
- Timeout: TIMEOUT=16, N=3; stop the stream after 5 data bytes. 16 cycles later error=1 and words_loaded=1, with only addr 0 written.
  - Then pulse start and send a valid image -> done=1, error=0.
- Mid-load reset: drop RST_n for one edge during the 2nd word of a 4-word load. All outputs return to 0 and state is IDLE; no further rom_we until the next start.
- Ignored start: pulse start during DATA -> no change to counters or state. Start in DONE restarts at LEN_LO with done cleared.
